// File: rtl/pine_bus_pkg.sv
// Shared types and constants for the chip-select bus sequencer.
// Region indices follow the board memory map, decoded from addr[15:13].
package pine_bus_pkg;

    localparam int REGION_W    = 3;
    localparam int WAIT_W      = 4;
    localparam int NUM_REGIONS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } cs_state_e;

    localparam logic [REGION_W-1:0] REGION_ROM   = 3'd0;
    localparam logic [REGION_W-1:0] REGION_RAM0  = 3'd1;
    localparam logic [REGION_W-1:0] REGION_RAM1  = 3'd2;
    localparam logic [REGION_W-1:0] REGION_RAM2  = 3'd3;
    localparam logic [REGION_W-1:0] REGION_FLASH = 3'd4;
    localparam logic [REGION_W-1:0] REGION_EXP0  = 3'd5;
    localparam logic [REGION_W-1:0] REGION_EXP1  = 3'd6;
    localparam logic [REGION_W-1:0] REGION_IO    = 3'd7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cs_wait_regfile.sv
// Per-region wait-state register file: one 4-bit entry per region,
// synchronous write, combinational read of the region being accepted.
module cs_wait_regfile
    import pine_bus_pkg::*;
#(
    parameter logic [WAIT_W-1:0] WAIT_RST = 4'd3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [REGION_W-1:0] wr_sel,
    input  logic [WAIT_W-1:0]   wr_data,
    input  logic [REGION_W-1:0] rd_sel,
    output logic [WAIT_W-1:0]   rd_data
);

    logic [WAIT_W-1:0] wait_r [NUM_REGIONS];

    // Register array update; a read in the same cycle as a write sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                wait_r[i] <= WAIT_RST;
            end
        end else if (wr_en) begin
            wait_r[wr_sel] <= wr_data;
        end
    end

    assign rd_data = wait_r[rd_sel];

endmodule

// File: rtl/chip_select_sequencer.sv
// Bus-cycle sequencer for the SN74F138 chip-select decoder: SETUP, STROBE
// and HOLD phases with a per-region programmable strobe length.
module chip_select_sequencer
    import pine_bus_pkg::*;
#(
    parameter int                SETUP_CYC = 1,
    parameter int                HOLD_CYC  = 1,
    parameter logic [WAIT_W-1:0] WAIT_RST  = 4'd3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                req_we,
    input  logic [15:0]         req_addr,
    output logic                ack,
    output logic                busy,
    output logic [REGION_W-1:0] dec_abc,
    output logic                dec_g1,
    output logic                dec_g2_n,
    output logic                oe_n,
    output logic                we_n,
    input  logic                cfg_we,
    input  logic [REGION_W-1:0] cfg_sel,
    input  logic [WAIT_W-1:0]   cfg_wait
);

    localparam int CNT_MAX = max3(SETUP_CYC, HOLD_CYC, 16);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    cs_state_e           state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [REGION_W-1:0] region_r, region_s;
    logic                we_r, we_s;
    logic [WAIT_W-1:0]   wcnt_r, wcnt_s;
    logic [WAIT_W-1:0]   wait_rd_s;

    logic                ack_s, busy_s, g1_s, oe_n_s, we_n_s;
    logic [REGION_W-1:0] abc_s;

    logic unused_addr_s;
    assign unused_addr_s = ^req_addr[12:0];

    cs_wait_regfile #(
        .WAIT_RST (WAIT_RST)
    ) u_wait_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_we),
        .wr_sel  (cfg_sel),
        .wr_data (cfg_wait),
        .rd_sel  (req_addr[15:13]),
        .rd_data (wait_rd_s)
    );

    // Next-state and phase-counter logic; the counter counts down to zero in each phase.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        region_s = region_r;
        we_s     = we_r;
        wcnt_s   = wcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    region_s = req_addr[15:13];
                    we_s     = req_we;
                    wcnt_s   = wait_rd_s;
                    cnt_s    = SETUP_LOAD;
                    state_s  = ST_SETUP;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == '0) begin
                    cnt_s   = CNT_W'(wcnt_r);
                    state_s = ST_STROBE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_r == '0) begin
                    cnt_s   = HOLD_LOAD;
                    state_s = ST_HOLD;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so they register in step with it.
    always_comb begin
        busy_s = 1'b0;
        abc_s  = region_s;
        g1_s   = 1'b0;
        oe_n_s = 1'b1;
        we_n_s = 1'b1;
        ack_s  = 1'b0;
        if (state_s != ST_IDLE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        if (state_s == ST_STROBE) begin
            g1_s   = 1'b1;
            oe_n_s = we_s;
            we_n_s = !we_s;
        end else begin
            g1_s   = 1'b0;
            oe_n_s = 1'b1;
            we_n_s = 1'b1;
        end
        if ((state_s == ST_HOLD) && (cnt_s == '0)) begin
            ack_s = 1'b1;
        end else begin
            ack_s = 1'b0;
        end
    end

    // State, transaction context and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            region_r <= 3'd0;
            we_r     <= 1'b0;
            wcnt_r   <= 4'd0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            dec_abc  <= 3'd0;
            dec_g1   <= 1'b0;
            dec_g2_n <= 1'b1;
            oe_n     <= 1'b1;
            we_n     <= 1'b1;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            region_r <= region_s;
            we_r     <= we_s;
            wcnt_r   <= wcnt_s;
            ack      <= ack_s;
            busy     <= busy_s;
            dec_abc  <= abc_s;
            dec_g1   <= g1_s;
            dec_g2_n <= !g1_s;
            oe_n     <= oe_n_s;
            we_n     <= we_n_s;
        end
    end

endmodule

// File: tb/tb_chip_select_sequencer.sv
// Bench for chip_select_sequencer paired with a behavioural SN74F138 model.
module tb_chip_select_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req_we;
    logic [15:0] req_addr;
    logic        ack, busy;
    logic [2:0]  dec_abc;
    logic        dec_g1, dec_g2_n, oe_n, we_n;
    logic        cfg_we;
    logic [2:0]  cfg_sel;
    logic [3:0]  cfg_wait;
    logic [7:0]  y;

    int n_checks = 0;
    int n_fail   = 0;
    int inv_bad  = 0;

    chip_select_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .ack      (ack),
        .busy     (busy),
        .dec_abc  (dec_abc),
        .dec_g1   (dec_g1),
        .dec_g2_n (dec_g2_n),
        .oe_n     (oe_n),
        .we_n     (we_n),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_wait (cfg_wait)
    );

    always #5 clk = ~clk;

    // SN74F138 as wired on the board: output Yn goes low for select value n.
    function automatic logic [7:0] f138(input logic [2:0] sel, input logic g1,
                                        input logic g2a_n, input logic g2b_n);
        logic [7:0] r;
        r = 8'hFF;
        if (g1 && !g2a_n && !g2b_n) r[sel] = 1'b0;
        return r;
    endfunction

    assign y = f138(dec_abc, dec_g1, dec_g2_n, dec_g2_n);

    logic       prev_g1 = 1'b0;
    logic [2:0] prev_abc = 3'd0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!oe_n && !we_n) inv_bad++;
            if (!dec_g1 && (!oe_n || !we_n)) inv_bad++;
            if (prev_g1 && dec_g1 && (dec_abc != prev_abc)) inv_bad++;
            if (dec_g2_n == dec_g1) inv_bad++;
        end
        prev_g1  <= dec_g1;
        prev_abc <= dec_abc;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] sel, input logic [3:0] w);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wait = w;
        @(posedge clk); @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Runs one transaction from an IDLE negedge; optionally a cfg write in the accept cycle.
    task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [7:0] exp_y,
                           input logic c_en, input logic [2:0] c_sel, input logic [3:0] c_wait,
                           output int n_busy, output int n_oe, output int n_we,
                           output int ack_at, output int y_bad,
                           output int after_busy, output int after_ack);
        int k;
        n_busy = 0; n_oe = 0; n_we = 0; y_bad = 0; ack_at = -1; k = 0;
        req = 1'b1; req_we = t_we; req_addr = t_addr;
        cfg_we = c_en; cfg_sel = c_sel; cfg_wait = c_wait;
        while (ack_at < 0 && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
            cfg_we = 1'b0;
            if (busy) n_busy++;
            if (!oe_n) n_oe++;
            if (!we_n) n_we++;
            if (dec_g1 ? (y !== exp_y) : (y !== 8'hFF)) y_bad++;
            if (ack) begin
                ack_at = k;
                req = 1'b0;
            end
        end
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        after_busy = int'(busy);
        after_ack  = int'(ack);
    endtask

    typedef struct {
        logic       cfg_en;
        logic [2:0] cfg_sel;
        logic [3:0] cfg_wait;
        logic       we;
        logic [15:0] addr;
        int         exp_busy;
        int         exp_oe;
        int         exp_we;
        logic [7:0] exp_y;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int nb, no, nw, aa, yb, ab, aq, k, got;

        // busy = SETUP(1) + STROBE(1+wait) + HOLD(1); ack lands on the last busy cycle
        vecs[0] = '{1'b0, 3'd0, 4'd0,  1'b0, 16'hA000,  6,  4, 0, 8'hDF};
        vecs[1] = '{1'b1, 3'd2, 4'd0,  1'b1, 16'h4000,  3,  0, 1, 8'hFB};
        vecs[2] = '{1'b1, 3'd7, 4'd15, 1'b0, 16'hE000, 18, 16, 0, 8'h7F};
        vecs[3] = '{1'b0, 3'd0, 4'd0,  1'b1, 16'h2000,  6,  0, 4, 8'hFD};
        vecs[4] = '{1'b1, 3'd0, 4'd1,  1'b0, 16'h0000,  4,  2, 0, 8'hFE};

        rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = 16'h0000;
        cfg_we = 1'b0; cfg_sel = 3'd0; cfg_wait = 4'd0;
        #12;
        chk("rst ack", int'(ack), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst dec_abc", int'(dec_abc), 0);
        chk("rst g1", int'(dec_g1), 0);
        chk("rst g2_n", int'(dec_g2_n), 1);
        chk("rst oe_n", int'(oe_n), 1);
        chk("rst we_n", int'(we_n), 1);
        chk("rst y", int'(y), 255);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].cfg_en) cfg(vecs[i].cfg_sel, vecs[i].cfg_wait);
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].exp_y, 1'b0, 3'd0, 4'd0,
                    nb, no, nw, aa, yb, ab, aq);
            chk($sformatf("v%0d busy cycles", i), nb, vecs[i].exp_busy);
            chk($sformatf("v%0d oe_n low", i), no, vecs[i].exp_oe);
            chk($sformatf("v%0d we_n low", i), nw, vecs[i].exp_we);
            chk($sformatf("v%0d ack cycle", i), aa, vecs[i].exp_busy);
            chk($sformatf("v%0d decoder Y", i), yb, 0);
            chk($sformatf("v%0d idle busy", i), ab, 0);
            chk($sformatf("v%0d ack single", i), aq, 0);
        end

        // back-to-back with req held: region 1 then region 6
        req = 1'b1; req_we = 1'b0; req_addr = 16'h2000; k = 0; got = 0;
        while (!got && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (ack) got = 1;
        end
        chk("b2b first ack", got ? k : -1, 6);
        req_addr = 16'hC000;
        @(posedge clk); @(negedge clk);
        chk("b2b gap busy", int'(busy), 0);
        chk("b2b gap abc held", int'(dec_abc), 1);
        @(posedge clk); @(negedge clk);
        chk("b2b second setup busy", int'(busy), 1);
        chk("b2b second abc", int'(dec_abc), 6);
        chk("b2b second g1", int'(dec_g1), 0);
        req = 1'b0; k = 1;
        while (!ack && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        chk("b2b second ack", ack ? k : -1, 6);
        @(posedge clk); @(negedge clk);

        // cfg write coinciding with acceptance of the same region
        run_txn(1'b0, 16'h6000, 8'hF7, 1'b1, 3'd3, 4'd9, nb, no, nw, aa, yb, ab, aq);
        chk("coinc old oe_n low", no, 4);
        chk("coinc old ack", aa, 6);
        run_txn(1'b0, 16'h6000, 8'hF7, 1'b0, 3'd0, 4'd0, nb, no, nw, aa, yb, ab, aq);
        chk("coinc new oe_n low", no, 10);
        chk("coinc new ack", aa, 12);
        chk("coinc new Y", yb, 0);

        // reset in the middle of a long strobe
        req = 1'b1; req_we = 1'b0; req_addr = 16'hE000; k = 0; got = 0;
        while (got < 3 && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (!oe_n) got++;
        end
        chk("mid strobe reached", got, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst oe_n", int'(oe_n), 1);
        chk("mid rst we_n", int'(we_n), 1);
        chk("mid rst g1", int'(dec_g1), 0);
        chk("mid rst g2_n", int'(dec_g2_n), 1);
        chk("mid rst busy", int'(busy), 0);
        got = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (ack) got++;
        end
        chk("mid rst no ack", got, 0);
        req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 16'hE000, 8'h7F, 1'b0, 3'd0, 4'd0, nb, no, nw, aa, yb, ab, aq);
        chk("post rst r7 oe_n low", no, 4);
        chk("post rst r7 ack", aa, 6);
        run_txn(1'b1, 16'h4000, 8'hFB, 1'b0, 3'd0, 4'd0, nb, no, nw, aa, yb, ab, aq);
        chk("post rst r2 we_n low", nw, 4);

        chk("invariants", inv_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
